jtag_tap_controller: RTL and testbench
======================================

# jtag_tap_controller

IEEE 1149.1 TAP state machine, the stage directly upstream of the JTAG instruction register and data registers. Advances on `tms` each `clk` edge and decodes the 16-state FSM into capture/shift/update strobes for the IR and DR paths. Also selects the serial `tdo` source between IR and DR shift outputs. Sits between the JTAG pins and the IR/DR register bank.

## Interface
Parameters:
- `IDLE_CNT_W`, 16, width of the optional Run-Test/Idle cycle counter

Ports:
- `clk`  in  1  TAP clock (TCK domain); all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `tms`  in  1  test mode select, sampled on rising `clk`
- `ir_tdo`  in  1  serial out of the instruction register
- `dr_tdo`  in  1  serial out of the selected data register
- `tdo`  out  1  serial output to pin
- `tdo_en`  out  1  high while in SHIFT_IR or SHIFT_DR
- `capture_ir`, `shift_ir`, `update_ir`  out  1 each  IR strobes
- `capture_dr`, `shift_dr`, `update_dr`  out  1 each  DR strobes
- `test_logic_reset`  out  1  high in TEST_LOGIC_RESET
- `run_test_idle`  out  1  high in RUN_TEST_IDLE
- `tap_state`  out  4  current state code
- `idle_cnt`  out  IDLE_CNT_W  consecutive RTI cycles (see Configuration)

## Operation
- State codes (fixed, 1149.1 convention): TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D.
- Transitions (tms=0 / tms=1): TLR→RTI/TLR; RTI→RTI/SEL_DR; SEL_DR→CAP_DR/SEL_IR; CAP_DR→SH_DR/EX1_DR; SH_DR→SH_DR/EX1_DR; EX1_DR→PAUSE_DR/UPD_DR; PAUSE_DR→PAUSE_DR/EX2_DR; EX2_DR→SH_DR/UPD_DR; UPD_DR→RTI/SEL_DR; SEL_IR→CAP_IR/TLR; IR branch mirrors DR; UPD_IR→RTI/SEL_DR.
- Five consecutive tms=1 samples reach TLR from any state.
- Strobes are Moore decodes of the registered state: `capture_ir`=(state==CAP_IR), `shift_ir`=(SH_IR), `update_ir`=(UPD_IR); DR likewise. At most one strobe high per cycle.
- `tdo` = `ir_tdo` in SH_IR, `dr_tdo` in SH_DR, else 0. Combinational mux; `tdo_en` = shift_ir | shift_dr.
- Unused codes cannot occur (all 16 used); no illegal-state recovery needed.

## Timing
- Reset: `rst_n`=0 at rising `clk` → state=TLR next cycle. Outputs after reset: `tap_state`=F, `test_logic_reset`=1, all strobes 0, `run_test_idle`=0, `tdo`=0, `tdo_en`=0, `idle_cnt`=0.
- Reset wins over `tms`; reset asserted mid-shift aborts to TLR with no update strobe generated.
- State updates one cycle after `tms` sampled; strobe visible for the whole cycle the FSM is in that state, so the downstream register acts on the following edge.
- Capture strobe lasts exactly one cycle; shift strobe lasts one cycle per tms=0 in SH_*; update strobe exactly one cycle.

## Configuration
- `JTAG_TAP_IDLE_CNT_EN` defined: `idle_cnt` increments each cycle the state is RTI, saturates at all-ones, clears to 0 on the first cycle in any other state and on reset. Value equals number of completed RTI cycles in the current RTI stay.
- Undefined: `idle_cnt` tied to 0; no counter flops.

## Test plan
- Reset then tms=0 one cycle → `tap_state`=C, `run_test_idle`=1, `test_logic_reset`=0.
- From RTI, tms=1,1,0,0 → passes 7,4,E,A; `capture_ir`=1 exactly one cycle at E; with `ir_tdo`=1, `tdo`=1 and `tdo_en`=1 in A.
- From RTI, tms=1,0,0,0,0,1,0,1,0,1,1 → DR path 7,6,2,2,2,1,3,0,2,1,5; `shift_dr` high 4 cycles, `update_dr` one cycle; next tms=0 → C.
- From SH_DR, tms=1 for five cycles → reaches F; `update_dr` pulses once (UPD_DR), no capture strobes.
- `rst_n`=0 for one edge while in SH_IR → next cycle `tap_state`=F, `shift_ir`=0, `update_ir` never asserted.
- With `JTAG_TAP_IDLE_CNT_EN`: hold RTI 10 cycles → `idle_cnt`=10 at exit; after leaving RTI, `idle_cnt`=0; with IDLE_CNT_W=4, 20 RTI cycles → saturates at 15.

Source files
------------

// File: rtl/jtag_tap_controller_if.sv
// JTAG TAP controller bus: pin-side inputs, IR/DR strobes, tdo mux and status.
// The controller side uses the slave modport. The pin/register-bank side uses master.
interface jtag_tap_controller_if #(
    parameter int unsigned IDLE_CNT_W = 16
);
    logic                  tms;
    logic                  ir_tdo;
    logic                  dr_tdo;
    logic                  tdo;
    logic                  tdo_en;
    logic                  capture_ir;
    logic                  shift_ir;
    logic                  update_ir;
    logic                  capture_dr;
    logic                  shift_dr;
    logic                  update_dr;
    logic                  test_logic_reset;
    logic                  run_test_idle;
    logic [3:0]            tap_state;
    logic [IDLE_CNT_W-1:0] idle_cnt;

    modport master (
        output tms, ir_tdo, dr_tdo,
        input  tdo, tdo_en, capture_ir, shift_ir, update_ir, capture_dr, shift_dr,
               update_dr, test_logic_reset, run_test_idle, tap_state, idle_cnt
    );

    modport slave (
        input  tms, ir_tdo, dr_tdo,
        output tdo, tdo_en, capture_ir, shift_ir, update_ir, capture_dr, shift_dr,
               update_dr, test_logic_reset, run_test_idle, tap_state, idle_cnt
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP state machine with Moore-decoded IR/DR strobes and tdo mux.
// Optional Run-Test/Idle cycle counter enabled by defining JTAG_TAP_IDLE_CNT_EN.
module jtag_tap_controller #(
    parameter int unsigned IDLE_CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    jtag_tap_controller_if.slave bus
);

    // Encodings are the standard 1149.1 state codes, exposed on tap_state.
    typedef enum logic [3:0] {
        StTlr     = 4'hF,
        StRti     = 4'hC,
        StSelDr   = 4'h7,
        StCapDr   = 4'h6,
        StShDr    = 4'h2,
        StEx1Dr   = 4'h1,
        StPauseDr = 4'h3,
        StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5,
        StSelIr   = 4'h4,
        StCapIr   = 4'hE,
        StShIr    = 4'hA,
        StEx1Ir   = 4'h9,
        StPauseIr = 4'hB,
        StEx2Ir   = 4'h8,
        StUpdIr   = 4'hD
    } state_e;

    state_e state_q, state_d;

    // State register; reset wins over tms and aborts any shift without an update.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StTlr;
        else        state_q <= state_d;
    end

    // Next-state transitions driven by tms.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = bus.tms ? StTlr   : StRti;
            StRti:     state_d = bus.tms ? StSelDr : StRti;
            StSelDr:   state_d = bus.tms ? StSelIr : StCapDr;
            StCapDr:   state_d = bus.tms ? StEx1Dr : StShDr;
            StShDr:    state_d = bus.tms ? StEx1Dr : StShDr;
            StEx1Dr:   state_d = bus.tms ? StUpdDr : StPauseDr;
            StPauseDr: state_d = bus.tms ? StEx2Dr : StPauseDr;
            StEx2Dr:   state_d = bus.tms ? StUpdDr : StShDr;
            StUpdDr:   state_d = bus.tms ? StSelDr : StRti;
            StSelIr:   state_d = bus.tms ? StTlr   : StCapIr;
            StCapIr:   state_d = bus.tms ? StEx1Ir : StShIr;
            StShIr:    state_d = bus.tms ? StEx1Ir : StShIr;
            StEx1Ir:   state_d = bus.tms ? StUpdIr : StPauseIr;
            StPauseIr: state_d = bus.tms ? StEx2Ir : StPauseIr;
            StEx2Ir:   state_d = bus.tms ? StUpdIr : StShIr;
            StUpdIr:   state_d = bus.tms ? StSelDr : StRti;
        endcase
    end

    // Moore output decode and tdo source select.
    always_comb begin
        bus.capture_ir       = (state_q == StCapIr);
        bus.shift_ir         = (state_q == StShIr);
        bus.update_ir        = (state_q == StUpdIr);
        bus.capture_dr       = (state_q == StCapDr);
        bus.shift_dr         = (state_q == StShDr);
        bus.update_dr        = (state_q == StUpdDr);
        bus.test_logic_reset = (state_q == StTlr);
        bus.run_test_idle    = (state_q == StRti);
        bus.tap_state        = state_q;
        bus.tdo_en           = (state_q == StShIr) || (state_q == StShDr);
        bus.tdo              = 1'b0;
        if (state_q == StShIr)      bus.tdo = bus.ir_tdo;
        else if (state_q == StShDr) bus.tdo = bus.dr_tdo;
    end

`ifdef JTAG_TAP_IDLE_CNT_EN
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Counts completed RTI cycles of the current stay; zero on entry and elsewhere.
    always_comb begin
        idle_cnt_d = '0;
        if (state_d == StRti && state_q == StRti) begin
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_cnt_d;
    end

    assign bus.idle_cnt = idle_cnt_q;
`else
    assign bus.idle_cnt = '0;
`endif

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller; a second instance with IDLE_CNT_W=4 covers saturation.
module tb_jtag_tap_controller;

`ifdef JTAG_TAP_IDLE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    jtag_tap_controller_if #(.IDLE_CNT_W(16)) bus ();
    jtag_tap_controller_if #(.IDLE_CNT_W(4))  sbus ();

    jtag_tap_controller #(.IDLE_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    jtag_tap_controller #(.IDLE_CNT_W(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK edge with the given tms; sample 1 ns after the edge.
    task automatic step(input logic t);
        bus.tms  = t;
        sbus.tms = t;
        @(posedge clk);
        #1;
        chk("strobe_at_most_one",
            32'($countones({bus.capture_ir, bus.shift_ir, bus.update_ir,
                            bus.capture_dr, bus.shift_dr, bus.update_dr}) <= 1), 32'd1);
    endtask

    logic       dr_tms [11];
    logic [3:0] dr_exp [11];
    int         n_shift;
    int         n_upd;
    int         n_cap;
    int         n_updir;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.tms = 1'b1; bus.ir_tdo = 1'b0; bus.dr_tdo = 1'b0;
        sbus.tms = 1'b1; sbus.ir_tdo = 1'b0; sbus.dr_tdo = 1'b0;
        dr_tms = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        dr_exp = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5};

        // Reset state.
        step(1'b1);
        chk("rst_state", 32'(bus.tap_state), 32'hF);
        chk("rst_tlr", 32'(bus.test_logic_reset), 32'd1);
        chk("rst_rti", 32'(bus.run_test_idle), 32'd0);
        chk("rst_strobes", 32'({bus.capture_ir, bus.shift_ir, bus.update_ir,
                                bus.capture_dr, bus.shift_dr, bus.update_dr}), 32'd0);
        chk("rst_tdo", 32'({bus.tdo, bus.tdo_en}), 32'd0);
        chk("rst_idle_cnt", 32'(bus.idle_cnt), 32'd0);
        rst_n = 1'b1;

        // TLR -> RTI.
        step(1'b0);
        chk("rti_state", 32'(bus.tap_state), 32'hC);
        chk("rti_flag", 32'(bus.run_test_idle), 32'd1);
        chk("rti_tlr_low", 32'(bus.test_logic_reset), 32'd0);

        // IR path: 7, 4, E, A.
        step(1'b1);
        chk("ir_sel_dr", 32'(bus.tap_state), 32'h7);
        step(1'b1);
        chk("ir_sel_ir", 32'(bus.tap_state), 32'h4);
        step(1'b0);
        chk("ir_cap_state", 32'(bus.tap_state), 32'hE);
        chk("ir_cap_strobe", 32'(bus.capture_ir), 32'd1);
        chk("ir_cap_tdo_en", 32'(bus.tdo_en), 32'd0);
        bus.ir_tdo = 1'b1;
        bus.dr_tdo = 1'b0;
        step(1'b0);
        chk("ir_sh_state", 32'(bus.tap_state), 32'hA);
        chk("ir_cap_one_cycle", 32'(bus.capture_ir), 32'd0);
        chk("ir_sh_strobe", 32'(bus.shift_ir), 32'd1);
        chk("ir_sh_tdo", 32'(bus.tdo), 32'd1);
        chk("ir_sh_tdo_en", 32'(bus.tdo_en), 32'd1);
        step(1'b1);
        chk("ir_ex1", 32'(bus.tap_state), 32'h9);
        chk("ir_ex1_tdo", 32'(bus.tdo), 32'd0);
        step(1'b1);
        chk("ir_upd_state", 32'(bus.tap_state), 32'hD);
        chk("ir_upd_strobe", 32'(bus.update_ir), 32'd1);
        step(1'b0);
        chk("ir_back_rti", 32'(bus.tap_state), 32'hC);

        // DR path walk with pause and re-entry to shift.
        bus.ir_tdo = 1'b0;
        bus.dr_tdo = 1'b1;
        n_shift = 0;
        n_upd   = 0;
        for (int i = 0; i < 11; i++) begin
            step(dr_tms[i]);
            chk($sformatf("dr_walk_%0d", i), 32'(bus.tap_state), 32'(dr_exp[i]));
            if (bus.shift_dr) begin
                n_shift++;
                chk("dr_sh_tdo", 32'({bus.tdo, bus.tdo_en}), 32'd3);
            end
            if (bus.update_dr) n_upd++;
        end
        chk("dr_shift_cycles", 32'(n_shift), 32'd4);
        chk("dr_update_cycles", 32'(n_upd), 32'd1);
        step(1'b0);
        chk("dr_back_rti", 32'(bus.tap_state), 32'hC);
        chk("dr_update_done", 32'(bus.update_dr), 32'd0);

        // From SH_DR, five tms=1 reach TLR.
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("five_start_shdr", 32'(bus.tap_state), 32'h2);
        n_upd = 0;
        n_cap = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            if (bus.update_dr) n_upd++;
            if (bus.capture_dr || bus.capture_ir) n_cap++;
        end
        chk("five_tlr", 32'(bus.tap_state), 32'hF);
        chk("five_upd_dr", 32'(n_upd), 32'd1);
        chk("five_no_capture", 32'(n_cap), 32'd0);

        // Reset while in SH_IR aborts without update.
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("rst_mid_shir", 32'(bus.tap_state), 32'hA);
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        chk("rst_mid_state", 32'(bus.tap_state), 32'hF);
        chk("rst_mid_shift_ir", 32'(bus.shift_ir), 32'd0);
        chk("rst_mid_update_ir", 32'(bus.update_ir), 32'd0);
        n_updir = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            if (bus.update_ir) n_updir++;
        end
        chk("rst_mid_no_update", 32'(n_updir), 32'd0);

        // Idle counter: 10 completed RTI cycles, then clear on exit.
        step(1'b0);
        chk("idle_entry", 32'(bus.idle_cnt), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("idle_state", 32'(bus.tap_state), 32'hC);
        chk("idle_cnt_10", 32'(bus.idle_cnt), CntEn ? 32'd10 : 32'd0);
        chk("idle_small_10", 32'(sbus.idle_cnt), CntEn ? 32'd10 : 32'd0);
        step(1'b1);
        chk("idle_exit_state", 32'(bus.tap_state), 32'h7);
        chk("idle_exit_clear", 32'(bus.idle_cnt), 32'd0);

        // Saturation with the 4-bit instance.
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("sat_small_rti", 32'(sbus.tap_state), 32'hC);
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("sat_small_cnt", 32'(sbus.idle_cnt), CntEn ? 32'd15 : 32'd0);
        chk("sat_wide_cnt", 32'(bus.idle_cnt), CntEn ? 32'd20 : 32'd0);
        step(1'b1);
        chk("sat_small_clear", 32'(sbus.idle_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
